// File: rtl/rv_pkg.sv
// ============================================================================
// Module   : rv_pkg
// Purpose  : Shared arbiter state encoding and default timing constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

    localparam int unsigned C_TIMEOUT_DEF      = 255;
    localparam int unsigned C_STARVE_LIMIT_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/rv_mem_arbiter_if.sv
// ============================================================================
// Module   : rv_mem_arbiter_if
// Purpose  : Fetch, data and shared memory bus signals of the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rv_mem_arbiter_if;
    logic        i_ireq;
    logic [31:2] i_iaddr;
    logic        o_iack;
    logic        o_ierr;
    logic [31:0] o_irdata;

    logic        i_dreq;
    logic        i_dwe;
    logic [31:2] i_daddr;
    logic [3:0]  i_dsel;
    logic [31:0] i_dwdata;
    logic        o_dack;
    logic        o_derr;
    logic [31:0] o_drdata;

    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:2] o_bus_addr;
    logic [3:0]  o_bus_sel;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic        i_bus_err;
    logic [31:0] i_bus_rdata;

    modport slave (
        input  i_ireq, i_iaddr, i_dreq, i_dwe, i_daddr, i_dsel, i_dwdata,
        input  i_bus_ack, i_bus_err, i_bus_rdata,
        output o_iack, o_ierr, o_irdata, o_dack, o_derr, o_drdata,
        output o_bus_req, o_bus_we, o_bus_addr, o_bus_sel, o_bus_wdata
    );

    modport master (
        output i_ireq, i_iaddr, i_dreq, i_dwe, i_daddr, i_dsel, i_dwdata,
        output i_bus_ack, i_bus_err, i_bus_rdata,
        input  o_iack, o_ierr, o_irdata, o_dack, o_derr, o_drdata,
        input  o_bus_req, o_bus_we, o_bus_addr, o_bus_sel, o_bus_wdata
    );
endinterface

`default_nettype wire

// File: rtl/rv_mem_arbiter.sv
// ============================================================================
// Module   : rv_mem_arbiter
// Purpose  : Two-port (fetch/data) arbiter onto one memory bus with timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rv_mem_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT      = C_TIMEOUT_DEF,
    parameter int unsigned STARVE_LIMIT = C_STARVE_LIMIT_DEF
) (
    input  wire logic        i_clk,
    input  wire logic        i_reset_n,
    rv_mem_arbiter_if.slave  bus
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] C_TMO = TW'(TIMEOUT);
    localparam logic [SW-1:0] C_SL  = SW'(STARVE_LIMIT);

    arb_state_e    r_state;
    logic [TW-1:0] r_tcnt;
    logic [SW-1:0] r_starve;
    logic          r_bus_req, r_bus_we;
    logic [31:2]   r_bus_addr;
    logic [3:0]    r_bus_sel;
    logic [31:0]   r_bus_wdata;
    logic          r_iack, r_ierr, r_dack, r_derr;
    logic [31:0]   r_irdata, r_drdata;

    logic          w_ielig, w_delig, w_starved, w_gnt_d, w_gnt_i;
    logic [TW-1:0] w_tcnt_nxt;
    logic          w_fail;

    // A port still showing its ack/err is presenting a stale request
    assign w_ielig    = bus.i_ireq & ~r_iack & ~r_ierr;
    assign w_delig    = bus.i_dreq & ~r_dack & ~r_derr;
    assign w_starved  = (r_starve == C_SL);
    assign w_gnt_d    = w_delig & ~(w_ielig & w_starved);
    assign w_gnt_i    = w_ielig & ~w_gnt_d;
    assign w_tcnt_nxt = r_tcnt + TW'(1);
    assign w_fail     = bus.i_bus_err | (~bus.i_bus_ack & (w_tcnt_nxt == C_TMO));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_tcnt      <= '0;
            r_starve    <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= '0;
            r_bus_wdata <= '0;
            r_iack      <= 1'b0;
            r_ierr      <= 1'b0;
            r_dack      <= 1'b0;
            r_derr      <= 1'b0;
            r_irdata    <= '0;
            r_drdata    <= '0;
        end else begin
            r_iack <= 1'b0;
            r_ierr <= 1'b0;
            r_dack <= 1'b0;
            r_derr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!bus.i_ireq || w_gnt_i) begin
                        r_starve <= '0;
                    end else if (w_gnt_d && !w_starved) begin
                        r_starve <= r_starve + SW'(1);
                    end
                    if (w_gnt_d) begin
                        r_state     <= ST_GNT_D;
                        r_tcnt      <= '0;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= bus.i_dwe;
                        r_bus_addr  <= bus.i_daddr;
                        r_bus_sel   <= bus.i_dsel;
                        r_bus_wdata <= bus.i_dwdata;
                    end else if (w_gnt_i) begin
                        r_state     <= ST_GNT_I;
                        r_tcnt      <= '0;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= bus.i_iaddr;
                        r_bus_sel   <= 4'b1111;
                        r_bus_wdata <= '0;
                    end
                end
                ST_GNT_I, ST_GNT_D: begin
                    if (w_fail || bus.i_bus_ack) begin
                        r_state   <= ST_IDLE;
                        r_bus_req <= 1'b0;
                        if (w_fail) begin
                            if (r_state == ST_GNT_D) r_derr <= 1'b1;
                            else                     r_ierr <= 1'b1;
                        end else if (r_state == ST_GNT_D) begin
                            r_dack <= 1'b1;
                            if (!r_bus_we) r_drdata <= bus.i_bus_rdata;
                        end else begin
                            r_iack <= 1'b1;
                            if (!r_bus_we) r_irdata <= bus.i_bus_rdata;
                        end
                    end else begin
                        r_tcnt <= w_tcnt_nxt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_bus_req   = r_bus_req;
    assign bus.o_bus_we    = r_bus_we;
    assign bus.o_bus_addr  = r_bus_addr;
    assign bus.o_bus_sel   = r_bus_sel;
    assign bus.o_bus_wdata = r_bus_wdata;
    assign bus.o_iack      = r_iack;
    assign bus.o_ierr      = r_ierr;
    assign bus.o_irdata    = r_irdata;
    assign bus.o_dack      = r_dack;
    assign bus.o_derr      = r_derr;
    assign bus.o_drdata    = r_drdata;

endmodule

`default_nettype wire

// File: tb/tb_rv_mem_arbiter.sv
// ============================================================================
// Module   : tb_rv_mem_arbiter
// Purpose  : Self-checking bench for rv_mem_arbiter (table, directed, random).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rv_mem_arbiter;

    localparam int TMO = 8;
    localparam int SL  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_mem_arbiter_if bif ();

    rv_mem_arbiter #(.TIMEOUT(TMO), .STARVE_LIMIT(SL)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bif)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Transaction-level reference: one outstanding request, owner, wait count
    bit          m_busy, m_own_d;
    int          m_wait, m_starve;
    logic        m_bus_req, m_we;
    logic [31:2] m_addr;
    logic [3:0]  m_sel;
    logic [31:0] m_wdata, m_irdata, m_drdata;
    logic        m_iack, m_ierr, m_dack, m_derr;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] dut_vec();
        logic [66:0] a;
        a = bif.o_bus_req ? {bif.o_bus_we, bif.o_bus_addr, bif.o_bus_sel, bif.o_bus_wdata} : '0;
        return 160'({bif.o_bus_req, bif.o_iack, bif.o_ierr, bif.o_dack, bif.o_derr,
                     bif.o_irdata, bif.o_drdata, a});
    endfunction

    function automatic logic [159:0] model_vec();
        logic [66:0] a;
        a = m_bus_req ? {m_we, m_addr, m_sel, m_wdata} : '0;
        return 160'({m_bus_req, m_iack, m_ierr, m_dack, m_derr, m_irdata, m_drdata, a});
    endfunction

    task automatic model_reset();
        m_busy = 0; m_own_d = 0; m_wait = 0; m_starve = 0;
        m_bus_req = 0; m_we = 0; m_addr = '0; m_sel = '0; m_wdata = '0;
        m_irdata = '0; m_drdata = '0;
        m_iack = 0; m_ierr = 0; m_dack = 0; m_derr = 0;
    endtask

    task automatic model_step();
        logic ia, ie, da, de, ei, ed, gd, gi;
        ia = 0; ie = 0; da = 0; de = 0;
        if (m_busy) begin
            if (!bif.i_bus_err && bif.i_bus_ack) begin
                if (m_own_d) da = 1; else ia = 1;
                if (!m_we) begin
                    if (m_own_d) m_drdata = bif.i_bus_rdata;
                    else         m_irdata = bif.i_bus_rdata;
                end
                m_busy = 0;
            end else begin
                if (!bif.i_bus_err) m_wait++;
                if (bif.i_bus_err || m_wait == TMO) begin
                    if (m_own_d) de = 1; else ie = 1;
                    m_busy = 0;
                end
            end
            if (!m_busy) m_bus_req = 0;
        end else begin
            ei = bif.i_ireq && !m_iack && !m_ierr;
            ed = bif.i_dreq && !m_dack && !m_derr;
            gd = ed && !(ei && m_starve == SL);
            gi = ei && !gd;
            if (!bif.i_ireq || gi) m_starve = 0;
            else if (gd)           m_starve = (m_starve < SL) ? m_starve + 1 : SL;
            if (gd || gi) begin
                m_busy = 1; m_own_d = gd; m_wait = 0; m_bus_req = 1;
                m_we    = gd ? bif.i_dwe    : 1'b0;
                m_addr  = gd ? bif.i_daddr  : bif.i_iaddr;
                m_sel   = gd ? bif.i_dsel   : 4'b1111;
                m_wdata = gd ? bif.i_dwdata : 32'd0;
            end
        end
        m_iack = ia; m_ierr = ie; m_dack = da; m_derr = de;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("model", dut_vec(), model_vec());
    endtask

    typedef struct {
        logic       ireq, dreq, dwe, ack, err;
        logic [5:0] exp;   // {bus_req, bus_we, iack, ierr, dack, derr}
    } vec_t;

    vec_t tv [11];
    int   hi_cnt;
    bit   seen;

    initial begin
        bif.i_ireq = 0; bif.i_iaddr = '0; bif.i_dreq = 0; bif.i_dwe = 0;
        bif.i_daddr = '0; bif.i_dsel = '0; bif.i_dwdata = '0;
        bif.i_bus_ack = 0; bif.i_bus_err = 0; bif.i_bus_rdata = '0;

        tv[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b110000};
        tv[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000010};
        tv[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000};
        tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100000};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100000};
        tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000100};
        tv[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b100000};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000010};
        tv[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b100000};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'b001000};
        tv[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};

        model_reset();
        #12;
        chk("reset_state", dut_vec(), 160'd0);
        @(negedge clk);
        rst_n = 1;

        bif.i_iaddr = 30'h100; bif.i_daddr = 30'h10; bif.i_dsel = 4'b0011;
        bif.i_dwdata = 32'h1234_5678; bif.i_bus_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 11; i++) begin
            bif.i_ireq = tv[i].ireq; bif.i_dreq = tv[i].dreq; bif.i_dwe = tv[i].dwe;
            bif.i_bus_ack = tv[i].ack; bif.i_bus_err = tv[i].err;
            step();
            chk($sformatf("table_row%0d", i),
                160'({bif.o_bus_req, bif.o_bus_req & bif.o_bus_we, bif.o_iack,
                      bif.o_ierr, bif.o_dack, bif.o_derr}), 160'(tv[i].exp));
            if (i == 0)
                chk("write_attrs", 160'({bif.o_bus_addr, bif.o_bus_sel, bif.o_bus_wdata}),
                    160'({30'h10, 4'b0011, 32'h1234_5678}));
            if (i == 9)
                chk("irdata_after_drop", 160'(bif.o_irdata), 160'(32'hCAFE_F00D));
        end

        // Fetch read with a slow slave: attributes must hold until the ack
        bif.i_ireq = 1; bif.i_iaddr = 30'h155; bif.i_dreq = 0;
        bif.i_bus_ack = 0; bif.i_bus_err = 0; bif.i_bus_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("slow_attr%0d", k),
                160'({bif.o_bus_req, bif.o_bus_we, bif.o_bus_addr, bif.o_bus_sel, bif.o_bus_wdata}),
                160'({1'b1, 1'b0, 30'h155, 4'b1111, 32'd0}));
        end
        bif.i_bus_ack = 1;
        step();
        chk("slow_read", 160'({bif.o_iack, bif.o_dack, bif.o_irdata}), 160'({1'b1, 1'b0, 32'hDEAD_BEEF}));
        bif.i_ireq = 0; bif.i_bus_ack = 0;
        step();

        // Silent slave: timeout must end the cycle with an error
        bif.i_dreq = 1; bif.i_dwe = 0;
        hi_cnt = 0; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (bif.o_bus_req) hi_cnt++;
            if (bif.o_derr) seen = 1;
        end
        chk("timeout_len", 160'({seen, bif.o_bus_req, bif.o_dack, 8'(hi_cnt)}),
            160'({1'b1, 1'b0, 1'b0, 8'd8}));
        bif.i_dreq = 0;
        step();

        // Reset while the data port owns the bus
        bif.i_dreq = 1; bif.i_dwe = 1;
        step();
        chk("pre_reset_gnt", 160'(bif.o_bus_req), 160'(1'b1));
        rst_n = 0;
        model_reset();
        #1;
        chk("async_reset", dut_vec(), 160'd0);
        bif.i_dreq = 0; bif.i_bus_ack = 1;
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("no_ack_after_reset%0d", k), 160'({bif.o_dack, bif.o_derr}), 160'd0);
        end

        for (int c = 0; c < 3000; c++) begin
            bif.i_ireq       = ($urandom_range(0, 3) != 0);
            bif.i_iaddr      = 30'($urandom);
            bif.i_dreq       = ($urandom_range(0, 3) != 0);
            bif.i_dwe        = $urandom_range(0, 1) == 1;
            bif.i_daddr      = 30'($urandom);
            bif.i_dsel       = 4'($urandom);
            bif.i_dwdata     = $urandom;
            bif.i_bus_ack    = ($urandom_range(0, 2) == 0);
            bif.i_bus_err    = ($urandom_range(0, 15) == 0);
            bif.i_bus_rdata  = $urandom;
            if (c % 500 == 250) begin
                bif.i_bus_ack = 0; bif.i_bus_err = 0;
                for (int k = 0; k < 10; k++) step();
            end else begin
                step();
            end
            if (bif.o_iack + bif.o_ierr + bif.o_dack + bif.o_derr > 1)
                chk("single_pulse", 160'({bif.o_iack, bif.o_ierr, bif.o_dack, bif.o_derr}), 160'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
